// File: rtl/mac_pkg.sv
// mac_pkg: opcode/funct constants shared by the MAC ALU and its sequencer, plus the sequencer FSM states.
package mac_pkg;
    localparam logic [2:0] OP_MAC_COMMIT = 3'b100;
    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic       FUNCT_LOAD    = 1'b1;
    localparam logic       FUNCT_MAC     = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACC, S_READ, S_HOLD} state_e;
endpackage

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer streaming two sync-read operand vectors through the MAC ALU,
// one element per cycle, and returning the accumulated sum on a valid/ready port.
module mac_seq
    import mac_pkg::*;
#(
    parameter int REG_DATA_WIDTH = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int ADDR_WIDTH     = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_a,
    input  logic [ADDR_WIDTH-1:0]     base_b,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_a_addr,
    output logic [ADDR_WIDTH-1:0]     mem_b_addr,
    input  logic [REG_DATA_WIDTH-1:0] mem_a_data,
    input  logic [REG_DATA_WIDTH-1:0] mem_b_data,
    output logic                      mac_funct,
    output logic [OPCODE_WIDTH-1:0]   mac_opcode,
    output logic [REG_DATA_WIDTH-1:0] mac_rs1,
    output logic [REG_DATA_WIDTH-1:0] mac_rs2,
    input  logic [REG_DATA_WIDTH-1:0] mac_rd,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [REG_DATA_WIDTH-1:0] result
);
    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_a_q, base_a_d, base_b_q, base_b_d, rd_off;
    logic [LEN_WIDTH-1:0]      len_q, len_d, idx_q, idx_d;
    logic [REG_DATA_WIDTH-1:0] result_q, result_d;
    logic [LEN_WIDTH:0]        idx_nxt;
    logic                      last;

    // One bit wider so idx+1 == len is representable for the maximum length.
    assign idx_nxt = {1'b0, idx_q} + (LEN_WIDTH + 1)'(1);
    assign last    = idx_nxt == {1'b0, len_q};
    assign result  = result_q;

    always_comb begin
        state_d    = state_q;
        base_a_d   = base_a_q;
        base_b_d   = base_b_q;
        len_d      = len_q;
        idx_d      = idx_q;
        result_d   = result_q;
        busy       = state_q != S_IDLE;
        mem_rd_en  = 1'b0;
        rd_off     = '0;
        mac_funct  = FUNCT_MAC;
        mac_opcode = OPCODE_WIDTH'(OP_NOP);
        mac_rs1    = '0;
        mac_rs2    = '0;
        res_valid  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                base_a_d = base_a;
                base_b_d = base_b;
                len_d    = len;
                idx_d    = '0;
                state_d  = S_CLEAR;
            end
            S_CLEAR: begin
                mac_funct  = FUNCT_LOAD;
                mac_opcode = OPCODE_WIDTH'(OP_MAC_COMMIT);
                mem_rd_en  = 1'b1;
                state_d    = len_q != '0 ? S_ACC : S_READ;
            end
            // Data for element idx arrives now; the read for idx+1 is issued in the same cycle.
            S_ACC: begin
                mac_rs1    = mem_a_data;
                mac_rs2    = mem_b_data;
                mac_opcode = OPCODE_WIDTH'(OP_MAC_COMMIT);
                mem_rd_en  = !last;
                rd_off     = ADDR_WIDTH'(idx_nxt);
                idx_d      = idx_nxt[LEN_WIDTH-1:0];
                state_d    = last ? S_READ : S_ACC;
            end
            S_READ: begin
                result_d = mac_rd;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                res_valid = 1'b1;
                state_d   = res_ready ? S_IDLE : S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
        mem_a_addr = mem_rd_en ? base_a_q + rd_off : '0;
        mem_b_addr = mem_rd_en ? base_b_q + rd_off : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives mac_seq against sync-read RAMs and a behavioural MAC ALU, comparing each
// job's result, latency, opcode/read activity and address stream with a plain dot-product model.
module tb_mac_seq;
    localparam int DW = 16;
    localparam int OW = 3;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, res_ready = 1'b0;
    logic [AW-1:0] base_a = '0, base_b = '0;
    logic [LW-1:0] len = '0;
    logic          busy, mem_rd_en, mac_funct, res_valid;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [DW-1:0] mem_a_data, mem_b_data, mac_rs1, mac_rs2, mac_rd, result;
    logic [OW-1:0] mac_opcode;
    logic [DW-1:0] ram_a [256];
    logic [DW-1:0] ram_b [256];
    logic [DW-1:0] psum = 16'h1234;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data), .mac_funct(mac_funct),
        .mac_opcode(mac_opcode), .mac_rs1(mac_rs1), .mac_rs2(mac_rs2), .mac_rd(mac_rd),
        .res_valid(res_valid), .res_ready(res_ready), .result(result)
    );

    always @(posedge clk) if (mem_rd_en) begin
        mem_a_data <= ram_a[mem_a_addr];
        mem_b_data <= ram_b[mem_b_addr];
    end

    // Behavioural MAC ALU: psum deliberately starts non-zero and is never reset.
    assign mac_rd = mac_funct ? mac_rs2 : mac_rs1 * mac_rs2 + psum;
    always @(posedge clk) if (mac_opcode == 3'b100) psum <= mac_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dot(input int ba, input int bb, input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s += $signed(ram_a[(ba + i) % 256]) * $signed(ram_b[(bb + i) % 256]);
        return DW'(s);
    endfunction

    task automatic run_job(input string tag, input int ba, input int bb, input int n, input int stall);
        int            lat = 1, ops = 0, rds = 0;
        bit            addr_ok = 1'b1;
        logic [DW-1:0] exp_r;
        exp_r = dot(ba, bb, n);
        @(negedge clk);
        start = 1'b1; base_a = AW'(ba); base_b = AW'(bb); len = LW'(n);
        @(negedge clk);
        start = 1'b0;
        while (!res_valid && lat < 400) begin
            if (mac_opcode == 3'b100) ops++;
            if (mem_rd_en) begin
                if (mem_a_addr !== AW'(ba + rds) || mem_b_addr !== AW'(bb + rds)) addr_ok = 1'b0;
                rds++;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, n + 3);
        chk({tag, " commit_cycles"}, ops, n + 1);
        chk({tag, " reads"}, rds, n == 0 ? 1 : n);
        chk({tag, " addr_seq"}, addr_ok, 1);
        chk({tag, " result"}, result, exp_r);
        for (int i = 0; i < stall; i++) begin
            start = i[0];
            @(negedge clk);
            chk({tag, " stall_result"}, result, exp_r);
            chk({tag, " stall_busy"}, {busy, res_valid}, 2'b11);
        end
        res_ready = 1'b1;
        start = stall > 0;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        chk({tag, " release"}, {busy, res_valid}, 2'b00);
        @(negedge clk);
        chk({tag, " idle"}, {busy, mem_rd_en}, 2'b00);
    endtask

    initial begin
        int n, ba, bb;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = DW'($urandom);
            ram_b[i] = DW'($urandom);
        end
        repeat (2) @(negedge clk);
        chk("reset ctrl", {busy, mem_rd_en, res_valid, mac_funct, mac_opcode}, 0);
        chk("reset data", {mem_a_addr, mem_b_addr, result}, 0);
        chk("reset rs", {mac_rs1, mac_rs2}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ram_a[i] = DW'(i + 1);
            ram_b[i] = DW'(i + 5);
        end
        run_job("dot4", 0, 0, 4, 0);
        chk("dot4 value", result, 70);

        run_job("len0", 8'h10, 8'h30, 0, 0);
        chk("len0 value", result, 0);

        ram_a[8'h20] = -16'sd3; ram_a[8'h21] = 16'd200;
        ram_b[8'h40] = 16'd7;   ram_b[8'h41] = -16'sd2;
        run_job("neg", 8'h20, 8'h40, 2, 0);
        chk("neg value", result, 16'hFE5B);

        ram_a[8'h50] = 16'd256; ram_b[8'h60] = 16'd256;
        run_job("wrap", 8'h50, 8'h60, 1, 0);
        chk("wrap value", result, 0);

        run_job("addr_wrap", 8'hFE, 8'h80, 4, 0);
        run_job("stall", 8'h05, 8'h90, 3, 10);

        @(negedge clk);
        start = 1'b1; base_a = 8'h70; base_b = 8'hA0; len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async ctrl", {busy, mem_rd_en, res_valid, mac_funct, mac_opcode}, 0);
        chk("async data", {mem_a_addr, mem_b_addr, result}, 0);
        chk("async rs", {mac_rs1, mac_rs2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ram_a[8'hC0] = 1; ram_a[8'hC1] = 1;
        ram_b[8'hD0] = 1; ram_b[8'hD1] = 1;
        run_job("post_reset", 8'hC0, 8'hD0, 2, 0);
        chk("post_reset value", result, 2);

        for (int j = 0; j < 15; j++) begin
            n  = int'($urandom_range(0, 20));
            ba = int'($urandom_range(0, 255));
            bb = int'($urandom_range(0, 255));
            run_job("rand", ba, bb, n, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
